// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: SPI flash command sequencer for the flash emulator.
// Decodes READ (0x03), FAST_READ (0x0B), RDSR (0x05) and JEDEC ID (0x9F),
// collects the 24-bit address and fetches data over a req/ack memory port.
// Define SPI_SEQ_LOG_EN to add the log_strobe/log_cmd/log_addr outputs.
module spi_flash_sequencer #(
    parameter int unsigned ADDR_BITS   = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 spi_cs,
    input  logic                 spi_rx_strobe,
    input  logic [7:0]           spi_rx_data,
    output logic [7:0]           spi_tx_data,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_data
`ifdef SPI_SEQ_LOG_EN
    ,
    output logic                 log_strobe,
    output logic [7:0]           log_cmd,
    output logic [23:0]          log_addr
`endif
);

    localparam logic [7:0] CmdRead     = 8'h03;
    localparam logic [7:0] CmdFastRead = 8'h0B;
    localparam logic [7:0] CmdRdsr     = 8'h05;
    localparam logic [7:0] CmdJedec    = 8'h9F;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StDummy,
        StData,
        StStat,
        StJid,
        StIgnore
    } state_e;

    state_e      state_q;
    logic [1:0]  cs_sync;
    logic [23:0] addr_q;
    logic [1:0]  idx_q;
    logic [7:0]  cmd_q;
    logic        pend_q;     // a request is queued behind the outstanding one
    logic        discard_q;  // data of the outstanding request must not reach tx

    logic        deselect;
    logic        rx_take;
    logic [23:0] addr_shift;
    logic        issue;
    logic [23:0] issue_addr;

    assign deselect   = cs_sync[1];
    assign rx_take    = spi_rx_strobe && !deselect;
    assign addr_shift = {addr_q[15:0], spi_rx_data};

    // Decide whether this strobe launches a memory read, and at which address.
    always_comb begin
        issue      = 1'b0;
        issue_addr = addr_q;
        if (rx_take) begin
            unique case (state_q)
                StAddr: begin
                    if (idx_q == 2'd2 && cmd_q != CmdFastRead) begin
                        issue      = 1'b1;
                        issue_addr = addr_shift;
                    end
                end
                StDummy: issue = 1'b1;
                StData: begin
                    issue      = 1'b1;
                    issue_addr = addr_q + 24'd1;
                end
                default: ;
            endcase
        end
    end

    // Command FSM, tx byte and memory request handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cs_sync     <= 2'b11;
            addr_q      <= 24'd0;
            idx_q       <= 2'd0;
            cmd_q       <= 8'd0;
            pend_q      <= 1'b0;
            discard_q   <= 1'b0;
            spi_tx_data <= 8'hFF;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            cs_sync <= {cs_sync[0], spi_cs};

            // Finish the outstanding read, or launch the queued one a cycle later.
            if (mem_req && mem_ack) begin
                mem_req   <= 1'b0;
                discard_q <= 1'b0;
                if (!discard_q && !deselect && state_q == StData) begin
                    spi_tx_data <= mem_data;
                end
            end else if (!mem_req && pend_q && !deselect) begin
                mem_req  <= 1'b1;
                mem_addr <= addr_q[ADDR_BITS-1:0];
                pend_q   <= 1'b0;
            end

            if (deselect) begin
                state_q     <= StIdle;
                spi_tx_data <= 8'hFF;
                idx_q       <= 2'd0;
                pend_q      <= 1'b0;
                if (mem_req && !mem_ack) begin
                    discard_q <= 1'b1;
                end
            end else if (spi_rx_strobe) begin
                unique case (state_q)
                    StIdle: begin
                        cmd_q <= spi_rx_data;
                        idx_q <= 2'd0;
                        case (spi_rx_data)
                            CmdRead, CmdFastRead: state_q <= StAddr;
                            CmdRdsr: begin
                                state_q     <= StStat;
                                spi_tx_data <= STATUS_BYTE;
                            end
                            CmdJedec: begin
                                state_q     <= StJid;
                                spi_tx_data <= JEDEC_ID[23:16];
                            end
                            default: begin
                                state_q     <= StIgnore;
                                spi_tx_data <= 8'hFF;
                            end
                        endcase
                    end
                    StAddr: begin
                        addr_q      <= addr_shift;
                        idx_q       <= idx_q + 2'd1;
                        spi_tx_data <= 8'hFF;
                        if (idx_q == 2'd2) begin
                            state_q <= (cmd_q == CmdFastRead) ? StDummy : StData;
                        end
                    end
                    StDummy: begin
                        spi_tx_data <= 8'hFF;
                        state_q     <= StData;
                    end
                    StData: begin
                        spi_tx_data <= 8'hFF;
                        addr_q      <= addr_q + 24'd1;
                    end
                    StStat: spi_tx_data <= STATUS_BYTE;
                    StJid: begin
                        case (idx_q)
                            2'd0: begin
                                spi_tx_data <= JEDEC_ID[15:8];
                                idx_q       <= 2'd1;
                            end
                            2'd1: begin
                                spi_tx_data <= JEDEC_ID[7:0];
                                idx_q       <= 2'd2;
                            end
                            default: spi_tx_data <= 8'hFF;
                        endcase
                    end
                    StIgnore: spi_tx_data <= 8'hFF;
                    default: state_q <= StIdle;
                endcase
            end

            // A read while one is still in flight takes the single queued slot;
            // the in-flight data is then stale and gets dropped.
            if (issue) begin
                if (mem_req) begin
                    pend_q <= 1'b1;
                    if (!mem_ack) begin
                        discard_q <= 1'b1;
                    end
                end else begin
                    mem_req  <= 1'b1;
                    mem_addr <= issue_addr[ADDR_BITS-1:0];
                    pend_q   <= 1'b0;
                end
            end
        end
    end

`ifdef SPI_SEQ_LOG_EN
    logic log_fire;

    // The first read of a READ/FAST_READ marks the end of its address phase.
    assign log_fire = issue && (state_q != StData);

    // Log of the command and start address of each read burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            log_strobe <= 1'b0;
            log_cmd    <= 8'd0;
            log_addr   <= 24'd0;
        end else begin
            log_strobe <= log_fire;
            if (log_fire) begin
                log_cmd  <= cmd_q;
                log_addr <= issue_addr;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// tb_spi_flash_sequencer: randomized self-checking bench for spi_flash_sequencer.
module tb_spi_flash_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_cs;
    logic        spi_rx_strobe;
    logic [7:0]  spi_rx_data;
    logic [7:0]  spi_tx_data;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
`ifdef SPI_SEQ_LOG_EN
    logic        log_strobe;
    logic [7:0]  log_cmd;
    logic [23:0] log_addr;
`endif

    always #5 clk = ~clk;

    spi_flash_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .spi_cs        (spi_cs),
        .spi_rx_strobe (spi_rx_strobe),
        .spi_rx_data   (spi_rx_data),
        .spi_tx_data   (spi_tx_data),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data)
`ifdef SPI_SEQ_LOG_EN
        ,
        .log_strobe    (log_strobe),
        .log_cmd       (log_cmd),
        .log_addr      (log_addr)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  txn [16];
    int          txn_len = 0;
    logic [7:0]  salt;
    logic [23:0] exp_q [$];
    int          ack_delay_fixed = 0;
    bit          expect_load = 1'b1;
    bit          mem_enable = 1'b1;
    int          log_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ salt;
    endfunction

    // Byte the flash should present after byte i of the current transaction.
    function automatic logic [7:0] model_tx(input int i);
        logic [23:0] a;
        logic [7:0]  r;
        a = {txn[1], txn[2], txn[3]};
        case (txn[0])
            8'h03:   r = (i < 3) ? 8'hFF : mem_byte(a + 24'(i - 3));
            8'h0B:   r = (i < 4) ? 8'hFF : mem_byte(a + 24'(i - 4));
            8'h05:   r = 8'h00;
            8'h9F:   r = (i == 0) ? 8'hEF : (i == 1) ? 8'h40 : (i == 2) ? 8'h18 : 8'hFF;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    // Whether byte i of the current transaction starts a memory read, and where.
    function automatic bit model_req(input int i, output logic [23:0] a);
        logic [23:0] base;
        base = {txn[1], txn[2], txn[3]};
        a    = 24'd0;
        if (txn[0] == 8'h03 && i >= 3) begin
            a = base + 24'(i - 3);
            return 1'b1;
        end
        if (txn[0] == 8'h0B && i >= 4) begin
            a = base + 24'(i - 4);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Memory responder: checks each request against the expected address list.
    initial begin : mem_model
        logic [23:0] a;
        int          d;
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req && mem_enable) begin
                a = mem_addr;
                if (exp_q.size() == 0) begin
                    check("req_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("req_addr", 32'(a), 32'(exp_q.pop_front()));
                end
                d = (ack_delay_fixed != 0) ? ack_delay_fixed : int'($urandom_range(1, 4));
                repeat (d - 1) @(negedge clk);
                check("req_hold", 32'({mem_req, mem_addr}), 32'({1'b1, a}));
                mem_ack  = 1'b1;
                mem_data = mem_byte(a);
                @(negedge clk);
                mem_ack  = 1'b0;
                mem_data = 8'($urandom);
                check("req_drop", 32'(mem_req), 32'd0);
                if (expect_load) begin
                    check("ack_to_tx", 32'(spi_tx_data), 32'(mem_byte(a)));
                end
            end
        end
    end

`ifdef SPI_SEQ_LOG_EN
    always @(negedge clk) begin
        if (log_strobe === 1'b1) log_count <= log_count + 1;
    end
`endif

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        spi_rx_strobe = 1'b1;
        spi_rx_data   = b;
        @(negedge clk);
        spi_rx_strobe = 1'b0;
        spi_rx_data   = 8'($urandom);
    endtask

    task automatic run_txn();
        logic [23:0] ra;
        bit          rq;
        int          lc;
        lc = log_count;
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < txn_len; i++) begin
            rq = model_req(i, ra);
            if (rq) exp_q.push_back(ra);
            send_byte(txn[i]);
            check("req_rise", 32'(mem_req), 32'(rq));
            check("tx_latency", 32'(spi_tx_data), rq ? 32'hFF : 32'(model_tx(i)));
            repeat (12) @(negedge clk);
            check("tx_byte", 32'(spi_tx_data), 32'(model_tx(i)));
        end
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        check("desel_tx", 32'(spi_tx_data), 32'hFF);
        check("desel_req", 32'(mem_req), 32'd0);
        check("req_all_issued", 32'(exp_q.size()), 32'd0);
`ifdef SPI_SEQ_LOG_EN
        if (txn[0] == 8'h03 || txn[0] == 8'h0B) begin
            check("log_count", 32'(log_count), 32'(lc + 1));
            check("log_cmd", 32'(log_cmd), 32'(txn[0]));
            check("log_addr", 32'(log_addr), 32'({txn[1], txn[2], txn[3]}));
        end else begin
            check("log_none", 32'(log_count), 32'(lc));
        end
`endif
    endtask

    task automatic set_txn(input logic [7:0] c, input logic [23:0] a, input int n);
        txn[0] = c;
        txn[1] = a[23:16];
        txn[2] = a[15:8];
        txn[3] = a[7:0];
        for (int i = 4; i < 16; i++) txn[i] = 8'($urandom);
        txn_len = n;
    endtask

    initial begin : stim_main
        logic [23:0] ra;
        int          k;
        logic [7:0]  c;
        salt          = 8'($urandom);
        reset_n       = 1'b0;
        spi_cs        = 1'b1;
        spi_rx_strobe = 1'b0;
        spi_rx_data   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(spi_tx_data), 32'hFF);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // READ with a memory that acks two cycles after each request.
        ack_delay_fixed = 2;
        set_txn(8'h03, 24'h001020, 7);
        run_txn();
        ack_delay_fixed = 0;

        // FAST_READ across the top of the address space.
        set_txn(8'h0B, 24'hFFFFFF, 7);
        run_txn();

        set_txn(8'h9F, 24'($urandom), 5);
        run_txn();
        set_txn(8'h05, 24'($urandom), 4);
        run_txn();
        set_txn(8'h5A, 24'($urandom), 4);
        run_txn();

        // Deselect while a read is in flight; memory acks ten cycles later.
        set_txn(8'h03, 24'($urandom), 4);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        ack_delay_fixed = 10;
        expect_load     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (model_req(i, ra)) exp_q.push_back(ra);
            send_byte(txn[i]);
        end
        check("dsr_req_high", 32'(mem_req), 32'd1);
        spi_cs = 1'b1;
        repeat (6) @(negedge clk);
        check("dsr_req_hold", 32'(mem_req), 32'd1);
        repeat (20) @(negedge clk);
        check("dsr_tx", 32'(spi_tx_data), 32'hFF);
        check("dsr_req_low", 32'(mem_req), 32'd0);
        check("dsr_req_done", 32'(exp_q.size()), 32'd0);
        ack_delay_fixed = 0;
        expect_load     = 1'b1;
        set_txn(8'h03, 24'($urandom), 6);
        run_txn();

        set_txn(8'h03, 24'h123456, 5);
        run_txn();

        // Randomized command mix.
        for (int t = 0; t < 20; t++) begin
            k = int'($urandom_range(0, 4));
            case (k)
                0: set_txn(8'h03, 24'($urandom), 4 + int'($urandom_range(0, 4)));
                1: set_txn(8'h0B, 24'($urandom), 5 + int'($urandom_range(0, 3)));
                2: set_txn(8'h05, 24'($urandom), 1 + int'($urandom_range(0, 5)));
                3: set_txn(8'h9F, 24'($urandom), 1 + int'($urandom_range(0, 5)));
                default: begin
                    c = 8'($urandom);
                    if (c == 8'h03 || c == 8'h0B || c == 8'h05 || c == 8'h9F) c = 8'h5A;
                    set_txn(c, 24'($urandom), 1 + int'($urandom_range(0, 5)));
                end
            endcase
            run_txn();
        end

        // Asynchronous reset in the middle of a DATA burst with a read in flight.
        set_txn(8'h03, 24'hABCDEF, 4);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back(24'hABCDEF);
        for (int i = 0; i < 4; i++) send_byte(txn[i]);
        repeat (12) @(negedge clk);
        check("mid_tx", 32'(spi_tx_data), 32'(mem_byte(24'hABCDEF)));
        mem_enable = 1'b0;
        send_byte(8'($urandom));
        check("mid_req", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_tx", 32'(spi_tx_data), 32'hFF);
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
`ifdef SPI_SEQ_LOG_EN
        check("arst_log", 32'({log_strobe, log_cmd, log_addr} != '0), 32'd0);
`endif
        spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        reset_n    = 1'b1;
        mem_enable = 1'b1;
        repeat (3) @(negedge clk);
        set_txn(8'h03, 24'($urandom), 5);
        run_txn();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
